// File: rtl/compress_pkg.sv
// Shared constants, FSM state type and record-length check for the compressed stream packer.
package compress_pkg;

    localparam int MAX_REC_BYTES = 34;
    localparam int TAG_BYTES     = 2;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    function automatic logic rec_len_legal(input logic [7:0] len);
        return (len >= 8'(TAG_BYTES)) && (len <= 8'(MAX_REC_BYTES));
    endfunction

endpackage

// File: rtl/byte_shift_append.sv
// Combinational accumulator update: drop emitted bytes from the front, then append a record after the residue.
module byte_shift_append #(
    parameter int BUF_BYTES = 64,
    parameter int REC_BYTES = 34,
    parameter int FILL_W    = 7
) (
    input  logic [BUF_BYTES*8-1:0] i_acc,
    input  logic [FILL_W-1:0]      i_fill,
    input  logic [FILL_W-1:0]      i_shift,
    input  logic [REC_BYTES*8-1:0] i_recBytes,
    input  logic [FILL_W-1:0]      i_recLen,
    output logic [BUF_BYTES*8-1:0] o_acc,
    output logic [FILL_W-1:0]      o_fill
);

    localparam int ACC_W = BUF_BYTES * 8;

    logic [FILL_W-1:0] w_resid;
    logic [ACC_W-1:0]  w_recPad;
    logic [ACC_W-1:0]  w_recMask;
    logic [ACC_W-1:0]  w_shifted;

    // Bytes beyond fill are kept at zero, so the residue and the masked record can simply be OR-ed.
    always_comb begin
        w_resid   = i_fill - i_shift;
        w_recPad  = {{(ACC_W - REC_BYTES*8){1'b0}}, i_recBytes};
        w_recMask = ~({ACC_W{1'b1}} << {i_recLen, 3'b000});
        w_shifted = i_acc >> {i_shift, 3'b000};
        o_acc     = w_shifted | ((w_recPad & w_recMask) << {w_resid, 3'b000});
        o_fill    = w_resid + i_recLen;
    end

endmodule

// File: rtl/compressed_stream_packer.sv
// Packs tag+payload records into a dense stream of OUT_BYTES-wide words with valid/ready flow control.
module compressed_stream_packer
    import compress_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 8,
    parameter int TAG_WIDTH  = 2,
    parameter int LEN_WIDTH  = 8,
    parameter int OUT_BYTES  = 8,
    parameter int BUF_BYTES  = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            validIn,
    output logic                            inReady,
    input  logic [DATA_WIDTH*NUM_LANES-1:0] dataIn,
    input  logic [TAG_WIDTH*NUM_LANES-1:0]  tagIn,
    input  logic [LEN_WIDTH-1:0]            lenIn,
    input  logic                            flushIn,
    output logic                            outValid,
    input  logic                            outReady,
    output logic [8*OUT_BYTES-1:0]          outData,
    output logic                            outLast,
    output logic                            errLen,
    output logic [31:0]                     byteCount
);

    localparam int REC_BYTES = (TAG_WIDTH*NUM_LANES + DATA_WIDTH*NUM_LANES) / 8;
    localparam int FILL_W    = $clog2(BUF_BYTES + 1);
    localparam int ACC_W     = BUF_BYTES * 8;
    localparam logic [FILL_W-1:0] READY_MAX = FILL_W'(BUF_BYTES - MAX_REC_BYTES);
    localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(OUT_BYTES);

    state_t              r_state;
    state_t              w_stateNext;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_accNext;
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   w_fillNext;
    logic [FILL_W-1:0]   w_shift;
    logic [FILL_W-1:0]   w_recLen;
    logic                r_errLen;
    logic [31:0]         r_byteCount;
    logic                w_accept;
    logic                w_legal;
    logic                w_emit;

    // Ready bound assumes a worst-case record, so it never depends on the offered lenIn.
    always_comb begin
        inReady   = !reset && (r_state == RUN) && (r_fill <= READY_MAX);
        outValid  = (r_fill >= WORD_FILL) || ((r_state == FLUSH) && (r_fill != '0));
        outLast   = (r_state == FLUSH) && (r_fill != '0) && (r_fill <= WORD_FILL);
        outData   = r_acc[8*OUT_BYTES-1:0];
        errLen    = r_errLen;
        byteCount = r_byteCount;
        w_accept  = validIn && inReady;
        w_legal   = rec_len_legal(lenIn);
        w_emit    = outValid && outReady;
        w_shift   = '0;
        if (w_emit) begin
            w_shift = (r_fill < WORD_FILL) ? r_fill : WORD_FILL;
        end
        w_recLen = '0;
        if (w_accept && w_legal) begin
            w_recLen = lenIn[FILL_W-1:0];
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            RUN: begin
                if (flushIn) begin
                    w_stateNext = FLUSH;
                end
            end
            FLUSH: begin
                if ((r_fill == '0) || (w_emit && (r_fill <= WORD_FILL))) begin
                    w_stateNext = RUN;
                end
            end
            default: w_stateNext = RUN;
        endcase
    end

    byte_shift_append #(
        .BUF_BYTES (BUF_BYTES),
        .REC_BYTES (REC_BYTES),
        .FILL_W    (FILL_W)
    ) u_shiftAppend (
        .i_acc      (r_acc),
        .i_fill     (r_fill),
        .i_shift    (w_shift),
        .i_recBytes ({dataIn, tagIn}),
        .i_recLen   (w_recLen),
        .o_acc      (w_accNext),
        .o_fill     (w_fillNext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_acc       <= '0;
            r_fill      <= '0;
            r_errLen    <= 1'b0;
            r_byteCount <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_acc       <= w_accNext;
            r_fill      <= w_fillNext;
            r_byteCount <= r_byteCount + 32'(w_shift);
            if (w_accept && !w_legal) begin
                r_errLen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_compressed_stream_packer.sv
// Directed self-checking bench for compressed_stream_packer with hand-computed expected words.
module tb_compressed_stream_packer;

    logic          clk = 1'b0;
    logic          reset;
    logic          validIn;
    logic          inReady;
    logic [255:0]  dataIn;
    logic [15:0]   tagIn;
    logic [7:0]    lenIn;
    logic          flushIn;
    logic          outValid;
    logic          outReady;
    logic [63:0]   outData;
    logic          outLast;
    logic          errLen;
    logic [31:0]   byteCount;

    int            numCompared = 0;
    int            numMismatched = 0;
    logic [7:0]    expBytes [72];

    compressed_stream_packer dut (
        .clk       (clk),
        .reset     (reset),
        .validIn   (validIn),
        .inReady   (inReady),
        .dataIn    (dataIn),
        .tagIn     (tagIn),
        .lenIn     (lenIn),
        .flushIn   (flushIn),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .outLast   (outLast),
        .errLen    (errLen),
        .byteCount (byteCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setRecord(input logic [15:0] tag, input logic [7:0] len, input logic [7:0] base);
        tagIn = tag;
        lenIn = len;
        for (int k = 0; k < 32; k++) begin
            dataIn[8*k +: 8] = base + 8'(k);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] tag, input logic [7:0] len, input logic [7:0] base);
        setRecord(tag, len, base);
        validIn = 1'b1;
        tick();
        validIn = 1'b0;
    endtask

    task automatic pulseFlush();
        flushIn = 1'b1;
        tick();
        flushIn = 1'b0;
    endtask

    function automatic logic [63:0] expWord(input int w);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) begin
            r[8*j +: 8] = expBytes[8*w + j];
        end
        return r;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset    = 1'b1;
        validIn  = 1'b0;
        dataIn   = '0;
        tagIn    = '0;
        lenIn    = '0;
        flushIn  = 1'b0;
        outReady = 1'b0;

        // Two back-to-back 34-byte records: tag 2010 + 30..4F, then tag 6050 + 70..8F.
        expBytes[0]  = 8'h10;
        expBytes[1]  = 8'h20;
        expBytes[34] = 8'h50;
        expBytes[35] = 8'h60;
        for (int k = 0; k < 32; k++) begin
            expBytes[2 + k]  = 8'h30 + 8'(k);
            expBytes[36 + k] = 8'h70 + 8'(k);
        end
        for (int k = 68; k < 72; k++) begin
            expBytes[k] = 8'h00;
        end

        #12;
        checkOutput("rst_inReady", inReady, 0);
        checkOutput("rst_outValid", outValid, 0);
        checkOutput("rst_outData", outData, 0);
        checkOutput("rst_outLast", outLast, 0);
        checkOutput("rst_errLen", errLen, 0);
        checkOutput("rst_byteCount", byteCount, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rel_inReady", inReady, 1);

        outReady = 1'b1;
        applyStimulus(16'hA1B2, 8'd10, 8'h00);
        checkOutput("t1_outValid", outValid, 1);
        checkOutput("t1_outData", outData, 64'h0504030201_00A1B2);
        checkOutput("t1_outLast", outLast, 0);
        checkOutput("t1_cntBefore", byteCount, 0);
        tick();
        checkOutput("t1_validAfter", outValid, 0);
        checkOutput("t1_byteCount", byteCount, 8);

        pulseFlush();
        checkOutput("t2_outValid", outValid, 1);
        checkOutput("t2_outData", outData, 64'h0000_0000_0000_0706);
        checkOutput("t2_outLast", outLast, 1);
        tick();
        checkOutput("t2_validAfter", outValid, 0);
        checkOutput("t2_lastAfter", outLast, 0);
        checkOutput("t2_byteCount", byteCount, 10);
        checkOutput("t2_inReady", inReady, 1);

        pulseFlush();
        checkOutput("fe_inReady", inReady, 0);
        checkOutput("fe_outValid", outValid, 0);
        checkOutput("fe_outLast", outLast, 0);
        tick();
        checkOutput("fe_backToRun", inReady, 1);

        outReady = 1'b0;
        setRecord(16'h2010, 8'd34, 8'h30);
        validIn = 1'b1;
        tick();
        setRecord(16'h6050, 8'd34, 8'h70);
        checkOutput("t3_inReadyLow", inReady, 0);
        checkOutput("t3_outValid", outValid, 1);
        checkOutput("t3_word0", outData, expWord(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t3_hold", outData, expWord(0));
            checkOutput("t3_holdReady", inReady, 0);
        end
        outReady = 1'b1;
        tick();
        checkOutput("t3_word1", outData, expWord(1));
        checkOutput("t3_readyBack", inReady, 1);
        tick();
        validIn = 1'b0;
        checkOutput("t3_word2", outData, expWord(2));
        checkOutput("t3_readyFull", inReady, 0);
        for (int w = 3; w < 8; w++) begin
            tick();
            checkOutput("t3_valid", outValid, 1);
            checkOutput("t3_word", outData, expWord(w));
        end
        tick();
        checkOutput("t3_partialIdle", outValid, 0);
        checkOutput("t3_byteCount", byteCount, 74);
        pulseFlush();
        checkOutput("t3_flushValid", outValid, 1);
        checkOutput("t3_flushLast", outLast, 1);
        checkOutput("t3_word8", outData, expWord(8));
        tick();
        checkOutput("t3_flushDone", outValid, 0);
        checkOutput("t3_byteCountEnd", byteCount, 78);

        applyStimulus(16'hC3C2, 8'd5, 8'hD0);
        checkOutput("t4_validShort", outValid, 0);
        checkOutput("t4_errClear", errLen, 0);
        applyStimulus(16'hEEEE, 8'd1, 8'h55);
        checkOutput("t4_errLen1", errLen, 1);
        checkOutput("t4_readyAfterBad", inReady, 1);
        checkOutput("t4_noWordAfterBad", outValid, 0);
        applyStimulus(16'hEEEE, 8'd40, 8'h55);
        checkOutput("t4_errLen40", errLen, 1);
        applyStimulus(16'hC5C4, 8'd5, 8'hE0);
        checkOutput("t4_outValid", outValid, 1);
        checkOutput("t4_outData", outData, 64'hE0C5C4D2D1D0C3C2);
        tick();
        checkOutput("t4_validAfter", outValid, 0);
        checkOutput("t4_byteCount", byteCount, 86);

        outReady = 1'b0;
        applyStimulus(16'hF1F0, 8'd6, 8'hA0);
        checkOutput("t5_outValid", outValid, 1);
        checkOutput("t5_outData", outData, 64'hA3A2A1A0F1F0E2E1);
        outReady = 1'b1;
        applyStimulus(16'hF3F2, 8'd6, 8'hB0);
        checkOutput("t5_validAfter", outValid, 0);
        checkOutput("t5_byteCount", byteCount, 94);
        pulseFlush();
        checkOutput("t5_flushData", outData, 64'h0000B3B2B1B0F3F2);
        checkOutput("t5_flushLast", outLast, 1);
        tick();
        checkOutput("t5_byteCountEnd", byteCount, 100);

        outReady = 1'b0;
        applyStimulus(16'h0101, 8'd10, 8'h00);
        applyStimulus(16'h0101, 8'd10, 8'h00);
        checkOutput("t6_inReady20", inReady, 1);
        pulseFlush();
        checkOutput("t6_flushValid", outValid, 1);
        checkOutput("t6_flushNotLast", outLast, 0);
        checkOutput("t6_flushReady", inReady, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_rstValid", outValid, 0);
        checkOutput("t6_rstData", outData, 0);
        checkOutput("t6_rstLast", outLast, 0);
        checkOutput("t6_rstErr", errLen, 0);
        checkOutput("t6_rstCount", byteCount, 0);
        checkOutput("t6_rstReady", inReady, 0);
        tick();
        reset = 1'b0;
        outReady = 1'b1;
        tick();
        tick();
        checkOutput("t6_noResidual", outValid, 0);
        checkOutput("t6_readyAfter", inReady, 1);
        checkOutput("t6_countAfter", byteCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
